// File: rtl/ctrl_net_tx_arbiter_pkg.sv
// Shared controller-network types: the user packet word carried on every TX source,
// the arbiter FSM state encoding and the width of the packed statistics word.
package ctrl_net_tx_arbiter_pkg;

  localparam int ARB_STATS_WIDTH = 64;
  localparam int PKT_ADDR_W      = 16;
  localparam int PKT_DATA_W      = 32;

  typedef struct packed {
    logic                  valid;
    logic                  last;
    logic [PKT_ADDR_W-1:0] addr;
    logic [PKT_DATA_W-1:0] data;
  } user_packet_word_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_t;

endpackage

// File: rtl/ctrl_net_tx_arbiter_rr_picker.sv
// Combinational round-robin finder: first set bit of pending scanning from rr_ptr upward
// with wrap-around. Shared with other schedulers on the controller network.
module ctrl_net_tx_arbiter_rr_picker #(
  parameter int NUM_REQ      = 4,
  parameter int REQ_ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]      pending,
  input  logic [REQ_ID_WIDTH-1:0] rr_ptr,
  output logic                    found,
  output logic [REQ_ID_WIDTH-1:0] idx
);

  always_comb begin
    int                    cand;
    logic [REQ_ID_WIDTH-1:0] sel;
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    sel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      sel = REQ_ID_WIDTH'(cand);
      if (!found && pending[sel]) begin
        found = 1'b1;
        idx   = sel;
      end
    end
  end

endmodule

// File: rtl/ctrl_net_tx_arbiter.sv
// Packet-level round-robin arbiter for the controller network TX port; a granted packet
// owns the port until its last word is accepted. Optional counters: CTRL_NET_TX_ARB_STATS_EN.
module ctrl_net_tx_arbiter
  import ctrl_net_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int REQ_ID_WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  user_packet_word_t          req_pkt [NUM_REQ],
  output logic [NUM_REQ-1:0]         req_ready,
  output user_packet_word_t          arb_tx,
  input  logic                       arb_tx_ready,
  output logic [REQ_ID_WIDTH-1:0]    grant_id,
  output logic                       grant_active,
  output logic [ARB_STATS_WIDTH-1:0] arb_stats
);

  arb_state_t              state, state_nxt;
  logic [REQ_ID_WIDTH-1:0] rr_ptr, rr_ptr_nxt, grant_nxt;
  logic [NUM_REQ-1:0]      pending;
  logic                    found;
  logic [REQ_ID_WIDTH-1:0] pick_idx;
  user_packet_word_t       owner_word;
  logic                    xfer, xfer_last;

  function automatic logic [REQ_ID_WIDTH-1:0] ptr_after(input logic [REQ_ID_WIDTH-1:0] g);
    if (int'(g) == NUM_REQ - 1) return '0;
    return g + REQ_ID_WIDTH'(1);
  endfunction

  always_comb begin
    pending = '0;
    for (int i = 0; i < NUM_REQ; i++) pending[i] = req_pkt[i].valid;
  end

  ctrl_net_tx_arbiter_rr_picker #(
    .NUM_REQ      (NUM_REQ),
    .REQ_ID_WIDTH (REQ_ID_WIDTH)
  ) u_rr_picker (
    .pending (pending),
    .rr_ptr  (rr_ptr),
    .found   (found),
    .idx     (pick_idx)
  );

  assign owner_word   = req_pkt[grant_id];
  assign grant_active = (state == ST_XFER);

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant_id;
    rr_ptr_nxt = rr_ptr;
    arb_tx     = '0;
    req_ready  = '0;
    xfer       = 1'b0;
    xfer_last  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (found) begin
          state_nxt = ST_XFER;
          grant_nxt = pick_idx;
        end
      end
      ST_XFER: begin
        // Owner keeps the port across valid gaps; only its last accepted word releases it.
        arb_tx              = owner_word;
        req_ready[grant_id] = arb_tx_ready;
        xfer                = owner_word.valid & arb_tx_ready;
        xfer_last           = xfer & owner_word.last;
        if (xfer_last) begin
          state_nxt  = ST_IDLE;
          rr_ptr_nxt = ptr_after(grant_id);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
    end else begin
      state    <= state_nxt;
      grant_id <= grant_nxt;
      rr_ptr   <= rr_ptr_nxt;
    end
  end

`ifdef CTRL_NET_TX_ARB_STATS_EN
  localparam int EXPORT_N = (NUM_REQ < 4) ? NUM_REQ : 4;

  logic [7:0]                 pkt_cnt [NUM_REQ];
  logic [15:0]                stall_cnt;
  logic                       stall;
  logic [ARB_STATS_WIDTH-1:0] stats_word;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign stall = (state == ST_XFER) & owner_word.valid & ~arb_tx_ready;

  always_comb begin
    stats_word        = '0;
    stats_word[47:32] = stall_cnt;
    for (int i = 0; i < EXPORT_N; i++) stats_word[8*i +: 8] = pkt_cnt[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) pkt_cnt[i] <= '0;
      stall_cnt <= '0;
      arb_stats <= '0;
    end else begin
      if (xfer_last) pkt_cnt[grant_id] <= pkt_cnt[grant_id] + 8'd1;
      if (stall) stall_cnt <= sat_inc16(stall_cnt);
      arb_stats <= stats_word;
    end
  end
`else
  assign arb_stats = '0;
`endif

endmodule
